// File: rtl/csa_acc_resolve.sv
// csa_acc_resolve
// Carry-save accumulator with a chunked carry-propagate resolver. It builds
// multi-operand partial-product sums for the field multiplier datapath.
// Operands arrive one per handshake. Each one is folded into a redundant
// sum/carry pair with a single 3:2 compression, so the cycle time does not
// depend on the operand width. After the last operand of a frame, the pair
// is converted to binary one CW-bit chunk per cycle. The result is then
// offered on a valid/ready output.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand present
//   in_ready   operand accepted this cycle (only in ACC, gated by rst)
//   in_data    W-bit operand, zero-extended to WA = W + G
//   in_last    operand closes the current frame
//   out_valid  result present (only in OUT)
//   out_ready  consumer accepts the result
//   out_data   frame sum mod 2^WA
//   out_ovf    frame held more than 2^G operands
module csa_acc_resolve #(
    parameter int W  = 74,
    parameter int G  = 4,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W+G-1:0]  out_data,
    output logic            out_ovf
);

    localparam int WA   = W + G;
    localparam int NCH  = (WA + CW - 1) / CW;
    // The top chunk is narrower than CW whenever WA is not a multiple of CW.
    localparam int TW   = WA - (NCH - 1) * CW;
    localparam int KW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNTW = G + 2;

    localparam logic [CNTW-1:0] CNT_SAT = CNTW'((1 << G) + 1);
    localparam logic [CNTW-1:0] CNT_LIM = CNTW'(1 << G);
    localparam logic [KW-1:0]   K_LAST  = KW'(NCH - 1);

    typedef enum logic [1:0] {
        ACC,
        RESOLVE,
        OUT
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [WA-1:0]   s_q;
    logic [WA-1:0]   c_q;
    logic [CNTW-1:0] cnt_q;
    logic [KW-1:0]   k_q;
    logic            cin_q;

    logic [WA-1:0]   x_ext;
    logic [WA-2:0]   maj_lo;
    logic [CW:0]     chunk_sum;
    logic            last_chunk;

    assign x_ext = {{G{1'b0}}, in_data};

    // The majority term is shifted left by one and truncated to WA bits.
    // So only its low WA-1 bits are needed.
    assign maj_lo = (s_q[WA-2:0] & c_q[WA-2:0])
                  | (s_q[WA-2:0] & x_ext[WA-2:0])
                  | (c_q[WA-2:0] & x_ext[WA-2:0]);

    // S and C are shifted right after every chunk.
    // So the current chunk is always their low CW bits.
    assign chunk_sum = {1'b0, s_q[CW-1:0]} + {1'b0, c_q[CW-1:0]}
                     + {{CW{1'b0}}, cin_q};

    assign last_chunk = (k_q == K_LAST);

    // Next state and handshake outputs.
    // rst reaches in_ready directly so that no operand is taken during reset.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACC: begin
                in_ready = !rst;
                if (in_valid && in_last) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                if (last_chunk) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // State register plus the accumulate and resolve datapath.
    // Result chunks enter out_data from the top. After the narrow final chunk,
    // chunk 0 has been shifted down to bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACC;
            s_q      <= '0;
            c_q      <= '0;
            cnt_q    <= '0;
            k_q      <= '0;
            cin_q    <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ACC: begin
                    if (in_valid) begin
                        s_q <= s_q ^ c_q ^ x_ext;
                        c_q <= {maj_lo, 1'b0};
                        if (cnt_q != CNT_SAT) begin
                            cnt_q <= cnt_q + CNTW'(1);
                        end
                        if (in_last) begin
                            k_q   <= '0;
                            cin_q <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    s_q   <= s_q >> CW;
                    c_q   <= c_q >> CW;
                    cin_q <= chunk_sum[CW];
                    k_q   <= k_q + KW'(1);
                    if (last_chunk) begin
                        out_data <= {chunk_sum[TW-1:0], out_data[WA-1:TW]};
                        out_ovf  <= (cnt_q > CNT_LIM);
                    end else begin
                        out_data <= {chunk_sum[CW-1:0], out_data[WA-1:CW]};
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        s_q   <= '0;
                        c_q   <= '0;
                        cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
